// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for the ALU: accepts one op, holds operands, sequences calculate, returns result.
// Latency: illegal -> DONE on accept edge; legal -> LOAD + N EXEC cycles; result held until res_ready.
module alu_op_sequencer #(
  parameter int MAX_EXEC = 15,
  parameter int CNT_W    = 8
) (
  input  logic             pulse,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [7:0]       in_opA,
  input  logic [7:0]       in_opB,
  output logic [3:0]       alu_opcode,
  output logic [7:0]       alu_opA,
  output logic [7:0]       alu_opB,
  output logic             alu_calculate,
  input  logic [15:0]      alu_coreOut,
  input  logic             alu_opComplete,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int EW = $clog2(MAX_EXEC + 1);
  localparam logic [EW-1:0] EXEC_LAST = EW'(MAX_EXEC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    exec_cnt_q, exec_cnt_d;
  logic [3:0]       opc_q, opc_d;
  logic [7:0]       opa_q, opa_d;
  logic [7:0]       opb_q, opb_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             in_ready_q, busy_q, res_valid_q, calc_q;

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = exec_cnt_q;
    opc_d      = opc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          opc_d      = in_opcode;
          opa_d      = in_opA;
          opb_d      = in_opB;
          exec_cnt_d = '0;
          if (in_opcode <= 4'd12) begin
            state_d = LOAD;
          end else begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = DONE;
          end
        end
      end
      LOAD: begin
        exec_cnt_d = '0;
        state_d    = EXEC;
      end
      EXEC: begin
        // Completion wins over a timeout landing on the same cycle.
        if (alu_opComplete) begin
          res_data_d = alu_coreOut;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else if (exec_cnt_q == EXEC_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = DONE;
        end else begin
          exec_cnt_d = exec_cnt_q + EW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pulse or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exec_cnt_q  <= '0;
      opc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      ops_done_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      calc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exec_cnt_q  <= exec_cnt_d;
      opc_q       <= opc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      ops_done_q  <= ops_done_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      res_valid_q <= (state_d == DONE);
      calc_q      <= (state_d == EXEC);
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign res_valid     = res_valid_q;
  assign alu_calculate = calc_q;
  assign alu_opcode    = opc_q;
  assign alu_opA       = opa_q;
  assign alu_opB       = opb_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU stub (add/xor/multiply).
module tb_alu_op_sequencer;

  logic        pulse = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_opcode;
  logic [7:0]  in_opA, in_opB;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_opA, alu_opB;
  logic        alu_calculate;
  logic [15:0] alu_coreOut;
  logic        alu_opComplete;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_err, busy;
  logic [7:0]  ops_done;

  int n_chk  = 0;
  int n_fail = 0;
  int calc_cycles = 0;
  int exp_ops = 0;
  int lat, c0;
  logic force_nc = 1'b0;
  logic [2:0] mcnt;
  logic [7:0] sum8, xor8;

  alu_op_sequencer #(.MAX_EXEC(15), .CNT_W(8)) dut (
    .pulse(pulse), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_opA(in_opA), .in_opB(in_opB),
    .alu_opcode(alu_opcode), .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_calculate(alu_calculate), .alu_coreOut(alu_coreOut), .alu_opComplete(alu_opComplete),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 pulse = ~pulse;

  // Multiplier stub: loads 7 while calculate is low, counts down while high, done at zero.
  always @(posedge pulse or negedge rst_n) begin
    if (!rst_n) mcnt <= 3'd0;
    else if (!alu_calculate) mcnt <= 3'd7;
    else if (mcnt != 3'd0) mcnt <= mcnt - 3'd1;
  end

  always_comb begin
    sum8 = alu_opA + alu_opB;
    xor8 = alu_opA ^ alu_opB;
    alu_coreOut = {8'h00, alu_opA & alu_opB};
    case (alu_opcode)
      4'd0:  alu_coreOut = {8'h00, sum8};
      4'd6:  alu_coreOut = {8'h00, xor8};
      4'd12: alu_coreOut = 16'(alu_opA) * 16'(alu_opB);
      default: alu_coreOut = {8'h00, alu_opA & alu_opB};
    endcase
    alu_opComplete = alu_calculate && !force_nc && ((alu_opcode != 4'd12) || (mcnt == 3'd0));
  end

  always @(posedge pulse) if (alu_calculate) calc_cycles <= calc_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pulse);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_opcode = op; in_opA = a; in_opB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handoff();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_ops++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_opA = '0; in_opB = '0; res_ready = 1'b0;
    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst calc", alu_calculate, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst ops_done", ops_done, 0);
    rst_n = 1'b1;
    tick();

    // T2 add
    c0 = calc_cycles;
    issue(4'd0, 8'hFF, 8'h02);
    chk("add in_ready low", in_ready, 0);
    chk("add busy", busy, 1);
    chk("add opA", alu_opA, 8'hFF);
    wait_valid(lat);
    chk("add latency", lat, 2);
    chk("add data", res_data, 16'h0001);
    chk("add err", res_err, 0);
    chk("add calc cycles", calc_cycles - c0, 1);
    handoff();
    chk("add ops_done", ops_done, exp_ops);
    chk("add back idle", in_ready, 1);

    // T3 multiply
    c0 = calc_cycles;
    issue(4'd12, 8'd13, 8'd11);
    chk("mul load calc", alu_calculate, 0);
    tick();
    chk("mul exec calc", alu_calculate, 1);
    lat = 1;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("mul latency", lat, 9);
    chk("mul data", res_data, 16'd143);
    chk("mul err", res_err, 0);
    chk("mul calc cycles", calc_cycles - c0, 8);
    chk("mul opB held", alu_opB, 8'd11);
    handoff();

    // T4 illegal
    c0 = calc_cycles;
    issue(4'd14, 8'h55, 8'hAA);
    wait_valid(lat);
    chk("ill valid after accept edge", lat, 0);
    chk("ill err", res_err, 1);
    chk("ill data", res_data, 16'h0000);
    handoff();
    chk("ill alu never run", calc_cycles - c0, 0);
    chk("ill ops_done", ops_done, exp_ops);

    // T5 backpressure
    issue(4'd6, 8'hF0, 8'h3C);
    wait_valid(lat);
    chk("bp latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp data held", res_data, 16'h00CC);
      chk("bp valid held", res_valid, 1);
      chk("bp in_ready low", in_ready, 0);
      chk("bp ops_done held", ops_done, exp_ops);
    end
    handoff();
    chk("bp ops_done inc", ops_done, exp_ops);
    chk("bp valid drop", res_valid, 0);
    chk("bp in_ready", in_ready, 1);

    // T6 timeout
    force_nc = 1'b1;
    c0 = calc_cycles;
    issue(4'd12, 8'd7, 8'd9);
    wait_valid(lat);
    chk("to latency", lat, 16);
    chk("to err", res_err, 1);
    chk("to data", res_data, 16'h0000);
    chk("to calc cycles", calc_cycles - c0, 15);
    handoff();
    force_nc = 1'b0;

    // T1 reset mid-EXEC of a multiply
    issue(4'd12, 8'd3, 8'd4);
    tick(); tick(); tick();
    chk("pre-rst calc", alu_calculate, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst calc", alu_calculate, 0);
    chk("mid rst opcode", alu_opcode, 0);
    chk("mid rst opA", alu_opA, 0);
    chk("mid rst opB", alu_opB, 0);
    chk("mid rst res_valid", res_valid, 0);
    chk("mid rst res_data", res_data, 0);
    chk("mid rst res_err", res_err, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ops_done", ops_done, 0);
    #2 rst_n = 1'b1;
    exp_ops = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("post rst no result", res_valid, 0);
    chk("post rst idle", busy, 0);

    // ops_done wrap over 256 handoffs
    c0 = calc_cycles;
    for (int i = 0; i < 256; i++) begin
      issue(4'd15, 8'h00, 8'h00);
      handoff();
      if (i == 127) chk("wrap midway", ops_done, 128);
    end
    chk("wrap ops_done", ops_done, 0);
    chk("wrap alu never run", calc_cycles - c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
